vga_scanout: RTL and testbench

- Downstream consumer of the TRS-80 capture path.
- Scans the 800x240 1-bpp framebuffer in dual-port RAM (read port) and drives an 800x600@60 Hz VGA monitor.
- Each source row is shown twice, centred vertically with a 60-line black border top and bottom.
- Runs entirely in the VGA pixel clock domain. It never writes the RAM and never touches the capture clock.

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_timing.sv | 68 ++++++
 rtl/vga_scanout.sv | 107 ++++++++++
 tb/tb_vga_scanout.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA 800x600@60 timing, framebuffer geometry and pixel types
package vga_pkg;

  localparam int H_VISIBLE = 800;
  localparam int H_FP      = 40;
  localparam int H_SYNC    = 128;
  localparam int H_BP      = 88;
  localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam int V_VISIBLE = 600;
  localparam int V_FP      = 1;
  localparam int V_SYNC    = 4;
  localparam int V_BP      = 23;
  localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int V_TOP     = 60;

  localparam int FB_WIDTH  = 800;
  localparam int FB_ROWS   = 240;
  localparam int FB_WORDS  = FB_WIDTH * FB_ROWS;

  localparam logic [11:0] FG_COLOR = 12'hFFF;

  typedef logic [17:0] fb_addr_t;
  typedef logic [11:0] rgb444_t;

  function automatic rgb444_t half_rgb(input rgb444_t c);
    return {1'b0, c[11:9], 1'b0, c[7:5], 1'b0, c[3:1]};
  endfunction

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - VGA raster counters, sync windows, active/band flags and frame tick
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int H_FP      = vga_pkg::H_FP,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BP      = vga_pkg::H_BP,
  parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int V_FP      = vga_pkg::V_FP,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BP      = vga_pkg::V_BP,
  parameter int V_TOP     = vga_pkg::V_TOP,
  parameter int SRC_ROWS  = vga_pkg::FB_ROWS
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [10:0] hcount,
  output logic [9:0]  vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic        band,
  output logic        line_end,
  output logic        frame_start
);

  localparam int HT       = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int VT       = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_VISIBLE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_VISIBLE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC - 1;
  localparam int BAND_END = V_TOP + 2 * SRC_ROWS - 1;

  logic [1:0] rst_sync;
  logic       run;

  // Reset asserts asynchronously but the counters only start two clocks after release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run      = rst_sync[1];
  assign line_end = run && (hcount == 11'(HT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcount <= '0;
      vcount <= '0;
    end else if (run) begin
      if (line_end) begin
        hcount <= '0;
        vcount <= (vcount == 10'(VT - 1)) ? '0 : vcount + 10'd1;
      end else begin
        hcount <= hcount + 11'd1;
      end
    end
  end

  assign hsync       = (hcount >= 11'(HS_START)) && (hcount <= 11'(HS_END));
  assign vsync       = (vcount >= 10'(VS_START)) && (vcount <= 10'(VS_END));
  assign active      = (hcount < 11'(H_VISIBLE)) && (vcount < 10'(V_VISIBLE));
  assign band        = (vcount >= 10'(V_TOP)) && (vcount <= 10'(BAND_END));
  assign frame_start = run && (hcount == '0) && (vcount == '0);

endmodule

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - line-doubled 1-bpp framebuffer scanout to VGA; VGA_SCANLINE_EN dims odd band lines
module vga_scanout
  import vga_pkg::*;
#(
  parameter int          H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int          H_FP      = vga_pkg::H_FP,
  parameter int          H_SYNC    = vga_pkg::H_SYNC,
  parameter int          H_BP      = vga_pkg::H_BP,
  parameter int          V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int          V_FP      = vga_pkg::V_FP,
  parameter int          V_SYNC    = vga_pkg::V_SYNC,
  parameter int          V_BP      = vga_pkg::V_BP,
  parameter int          V_TOP     = vga_pkg::V_TOP,
  parameter int          SRC_ROWS  = vga_pkg::FB_ROWS,
  parameter logic [11:0] FG_COLOR  = vga_pkg::FG_COLOR
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [17:0] raddr,
  input  logic        rdata,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        frame_start
);

`ifdef VGA_SCANLINE_EN
  localparam bit SCANLINE = 1'b1;
`else
  localparam bit SCANLINE = 1'b0;
`endif
  localparam int       BAND_END  = V_TOP + 2 * SRC_ROWS - 1;
  localparam bit       TOP_ODD   = 1'(V_TOP % 2);
  localparam fb_addr_t LINE_STEP = fb_addr_t'(H_VISIBLE);

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active;
    logic band;
    logic odd;
  } side_t;

  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hsync_i, vsync_i, active_i, band_i, line_end;
  logic        odd_line;
  fb_addr_t    line_base;
  side_t       side1, side2;
  rgb444_t     lit_color, rgb;

  vga_timing #(
    .H_VISIBLE(H_VISIBLE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VISIBLE(V_VISIBLE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .V_TOP(V_TOP), .SRC_ROWS(SRC_ROWS)
  ) u_timing (
    .clk(clk), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
    .hsync(hsync_i), .vsync(vsync_i), .active(active_i), .band(band_i),
    .line_end(line_end), .frame_start(frame_start)
  );

  assign odd_line = vcount[0] ^ TOP_ODD;

  // line_base sits at 0 everywhere outside the band, so the first band line always reads row 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_base <= '0;
    end else if (line_end) begin
      if (!band_i || (vcount == 10'(BAND_END))) line_base <= '0;
      else if (odd_line)                        line_base <= line_base + LINE_STEP;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      raddr <= '0;
      side1 <= '0;
      side2 <= '0;
    end else begin
      if (active_i && band_i) raddr <= line_base + fb_addr_t'(hcount);
      side1 <= {hsync_i, vsync_i, active_i, band_i, odd_line};
      side2 <= side1;
    end
  end

  always_comb begin
    lit_color = FG_COLOR;
    if (SCANLINE && side2.odd) lit_color = half_rgb(FG_COLOR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_hsync <= 1'b0;
      vga_vsync <= 1'b0;
      rgb       <= '0;
    end else begin
      vga_hsync <= side2.hsync;
      vga_vsync <= side2.vsync;
      rgb       <= (side2.active && side2.band && rdata) ? lit_color : '0;
    end
  end

  assign {vga_r, vga_g, vga_b} = rgb;

endmodule

// File: tb/tb_vga_scanout.sv
// tb/tb_vga_scanout.sv - randomized self-checking bench for vga_scanout against a raster-geometry model
`timescale 1ns/1ps
module tb_vga_scanout;

  localparam int HV = 40, HFP = 4, HS = 8, HBP = 12, HT = HV + HFP + HS + HBP;
  localparam int VV = 32, VFP = 1, VS = 2, VBP = 3, VT = VV + VFP + VS + VBP;
  localparam int VTOP = 4, ROWS = 12, WORDS = HV * ROWS, FT = HT * VT;
`ifdef VGA_SCANLINE_EN
  localparam bit SCANLINE = 1'b1;
`else
  localparam bit SCANLINE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [17:0] raddr, raddr_f;
  logic        rdata = 1'b0;
  logic        rdata_f = 1'b1;
  logic        hs, vs, fs, hs_f, vs_f, fs_f;
  logic [3:0]  r, g, b, r_f, g_f, b_f;

  bit mem [0:WORDS-1];
  int errors = 0;
  int checks = 0;
  int cyc;

  typedef struct {
    bit          hs;
    bit          vs;
    logic [11:0] rgb;
  } pix_t;

  always #12.5 clk = ~clk;

  always @(posedge clk or negedge reset_n)
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;

  always @(posedge clk)
    rdata <= (raddr < 18'(WORDS)) ? mem[int'(raddr)] : 1'b0;

  vga_scanout #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .V_TOP(VTOP), .SRC_ROWS(ROWS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .raddr(raddr), .rdata(rdata),
    .vga_hsync(hs), .vga_vsync(vs), .vga_r(r), .vga_g(g), .vga_b(b),
    .frame_start(fs)
  );

  vga_scanout dut_full (
    .clk(clk), .reset_n(reset_n), .raddr(raddr_f), .rdata(rdata_f),
    .vga_hsync(hs_f), .vga_vsync(vs_f), .vga_r(r_f), .vga_g(g_f), .vga_b(b_f),
    .frame_start(fs_f)
  );

  // Raster position s clocks after the counters start; framebuffer address or -1 if not shown.
  function automatic int expect_addr(int s);
    int h, v, ln;
    if (s < 0) return -1;
    h  = s % HT;
    v  = (s / HT) % VT;
    ln = v - VTOP;
    if (h < HV && v < VV && ln >= 0 && ln < 2 * ROWS) return (ln / 2) * HV + h;
    return -1;
  endfunction

  function automatic pix_t expect_pix(int s);
    pix_t p;
    int   a, h, v;
    p = '{1'b0, 1'b0, 12'h000};
    if (s < 0) return p;
    h = s % HT;
    v = (s / HT) % VT;
    p.hs = (h >= HV + HFP) && (h < HV + HFP + HS);
    p.vs = (v >= VV + VFP) && (v < VV + VFP + VS);
    a = expect_addr(s);
    if (a >= 0 && mem[a]) p.rgb = (SCANLINE && ((v - VTOP) % 2 == 1)) ? 12'h777 : 12'hFFF;
    return p;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checks++;
      if ({hs, vs, r, g, b, fs, hs_f, vs_f, r_f, g_f, b_f, fs_f} !== 30'd0 || raddr !== 18'd0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got hs=%b vs=%b rgb=%h fs=%b raddr=%0d full hs=%b vs=%b rgb=%h fs=%b, want all 0",
                 i, hs, vs, {r, g, b}, fs, raddr, hs_f, vs_f, {r_f, g_f, b_f}, fs_f);
      end
    end
  endtask

  task automatic test_full_timing();
    int rise1 = -1, rise2 = -1, fall1 = -1;
    bit prev = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    while (cyc < 845 + 1056 + 200) begin
      @(negedge clk);
      checks++;
      if (fs_f !== (cyc == 2)) begin
        errors++;
        $display("FAIL full_frame_start cycle %0d: got %b want %b", cyc, fs_f, (cyc == 2));
      end
      checks++;
      if ({vs_f, r_f, g_f, b_f} !== 13'd0) begin
        errors++;
        $display("FAIL full_top_lines cycle %0d: got vs=%b rgb=%h want vs=0 rgb=000", cyc, vs_f, {r_f, g_f, b_f});
      end
      if (hs_f && !prev) begin
        if (rise1 < 0) rise1 = cyc;
        else if (rise2 < 0) rise2 = cyc;
      end
      if (!hs_f && prev && fall1 < 0) fall1 = cyc;
      prev = hs_f;
    end
    checks++;
    if (rise1 != 845) begin
      errors++;
      $display("FAIL full_first_hsync: got cycle %0d want 845", rise1);
    end
    checks++;
    if (rise2 - rise1 != 1056) begin
      errors++;
      $display("FAIL full_hsync_period: got %0d want 1056", rise2 - rise1);
    end
    checks++;
    if (fall1 - rise1 != 128) begin
      errors++;
      $display("FAIL full_hsync_width: got %0d want 128", fall1 - rise1);
    end
  endtask

  // kind 0: random bits, 1: only first and last word lit, 2: all lit
  task automatic test_scan(input int kind, input int frames);
    pix_t e;
    int   ea, lit = 0, ones = 0;
    for (int a = 0; a < WORDS; a++) begin
      mem[a] = (kind == 0) ? 1'($urandom) : ((kind == 1) ? (a == 0 || a == WORDS - 1) : 1'b1);
      ones += int'(mem[a]);
    end
    repeat (8) @(negedge clk);
    for (int i = 0; i < frames * FT; i++) begin
      @(negedge clk);
      e = expect_pix(cyc - 5);
      checks++;
      if ({hs, vs, r, g, b} !== {e.hs, e.vs, e.rgb}) begin
        errors++;
        $display("FAIL scan_pixel kind=%0d cycle %0d: got hs=%b vs=%b rgb=%h want hs=%b vs=%b rgb=%h",
                 kind, cyc, hs, vs, {r, g, b}, e.hs, e.vs, e.rgb);
      end
      ea = expect_addr(cyc - 3);
      checks++;
      if (raddr >= 18'(WORDS) || (ea >= 0 && raddr !== 18'(ea))) begin
        errors++;
        $display("FAIL scan_raddr kind=%0d cycle %0d: got %0d want %0d (limit %0d)", kind, cyc, raddr, ea, WORDS - 1);
      end
      checks++;
      if (fs !== (((cyc - 2) % FT) == 0)) begin
        errors++;
        $display("FAIL scan_frame_start kind=%0d cycle %0d: got %b want %b", kind, cyc, fs, (((cyc - 2) % FT) == 0));
      end
      if ({r, g, b} != 12'h000) lit++;
    end
    checks++;
    if (lit != 2 * frames * ones) begin
      errors++;
      $display("FAIL scan_lit_count kind=%0d: got %0d want %0d", kind, lit, 2 * frames * ones);
    end
  endtask

  task automatic test_midframe_reset();
    int   target = (VTOP + 11) * HT + 20;
    int   guard = 0;
    pix_t e;
    for (int a = 0; a < WORDS; a++) mem[a] = 1'b1;
    repeat (8) @(negedge clk);
    while (((cyc - 5) % FT) != target && guard < 2 * FT) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 2 * FT) begin
      errors++;
      $display("FAIL midreset_reach_target: got no match in %0d cycles want raster pos %0d", guard, target);
    end
    e = expect_pix(cyc - 5);
    checks++;
    if ({r, g, b} !== e.rgb) begin
      errors++;
      $display("FAIL midreset_before: got rgb=%h want %h", {r, g, b}, e.rgb);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({hs, vs, r, g, b, fs, hs_f, vs_f, r_f, g_f, b_f, fs_f} !== 30'd0 || raddr !== 18'd0) begin
      errors++;
      $display("FAIL midreset_async: got rgb=%h raddr=%0d hs=%b vs=%b fs=%b full rgb=%h want all 0",
               {r, g, b}, raddr, hs, vs, fs, {r_f, g_f, b_f});
    end
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (fs !== (cyc == 2) || {r, g, b} !== 12'h000) begin
        errors++;
        $display("FAIL midreset_restart cycle %0d: got fs=%b rgb=%h want fs=%b rgb=000", cyc, fs, {r, g, b}, (cyc == 2));
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_timing();
    test_scan(0, 2);
    test_scan(1, 1);
    test_scan(2, 1);
    test_midframe_reset();
    test_scan(2, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
